// File: rtl/ila_arb_pkg.sv
// rtl/ila_arb_pkg.sv - shared types and constants for the ILA FIFO write arbiter
//
// Purpose: arbiter state encoding, channel-id width helper, counter widths.
// Ports:   none (package).
package ila_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int WR_CNT_W   = 16;
  // MAX_BURST tops out at 255, so 8 bits always hold beat_cnt.
  localparam int BEAT_CNT_W = 8;

  // A single channel still needs one id bit so GRANT_ID is never zero width.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ila_rr_pick.sv
// rtl/ila_rr_pick.sv - combinational round-robin requester picker
//
// Purpose: pick the first asserted req bit at or after rr_ptr, wrapping.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  ID_W     search start position
//   found   out 1        any request asserted
//   index   out ID_W     chosen requester
module ila_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic            found_hi;
  logic            found_lo;
  logic [ID_W-1:0] idx_hi;
  logic [ID_W-1:0] idx_lo;

  // Two searches: the first hit at or above rr_ptr wins; otherwise wrap to
  // the lowest asserted request overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        if (!found_hi && (j >= int'(rr_ptr))) begin
          found_hi = 1'b1;
          idx_hi   = ID_W'(j);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = ID_W'(j);
        end
      end
    end
  end

  assign found = found_lo;
  assign index = found_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/ila_fifo_wr_arb.sv
// rtl/ila_fifo_wr_arb.sv - round-robin burst arbiter driving the ILA capture FIFO write port
//
// Purpose: grant one capture channel at a time for up to MAX_BURST beats,
//   forward its samples to the FIFO write port, back off on full/almost-full.
// Config macro: ILA_ARB_TAG_EN packs GRANT_ID directly above the payload in B_DI.
// Ports:
//   CLK, RST (sync, active high)
//   REQ_VALID/REQ_DATA in, REQ_READY out   per-channel handshakes
//   B_EN/B_WE/B_DI/B_BM out                FIFO write port
//   F_FULL/F_ALMOST_FULL/F_WR_ERROR in     FIFO status
//   GRANT_VALID/GRANT_ID out               current burst owner
//   WR_CNT out (saturating), OVF_ERR out (sticky)
module ila_fifo_wr_arb
  import ila_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 16,
  parameter  int FIFO_W    = 20,
  parameter  int MAX_BURST = 8,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic                      B_EN,
  output logic                      B_WE,
  output logic [FIFO_W-1:0]         B_DI,
  output logic [FIFO_W-1:0]         B_BM,
  input  logic                      F_FULL,
  input  logic                      F_ALMOST_FULL,
  input  logic                      F_WR_ERROR,
  output logic                      GRANT_VALID,
  output logic [ID_W-1:0]           GRANT_ID,
  output logic [WR_CNT_W-1:0]       WR_CNT,
  output logic                      OVF_ERR
);

  arb_state_t            state, state_nxt;
  logic [ID_W-1:0]       grant, grant_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_nxt;
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_nxt;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic                  sel_valid;
  logic [DATA_W-1:0]     sel_data;
  logic                  beat;

  ila_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (REQ_VALID),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign sel_valid = REQ_VALID[grant];
  assign sel_data  = REQ_DATA[int'(grant)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    REQ_READY = '0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        REQ_READY[grant] = !F_FULL;
        beat = sel_valid && !F_FULL;
        if (beat) begin
          beat_nxt = beat_cnt + 1'b1;
        end
        // While full the burst is frozen: a dropped valid only ends it once
        // the FIFO has room again.
        if ((beat && ((beat_cnt == BEAT_CNT_W'(MAX_BURST - 1)) || F_ALMOST_FULL)) ||
            (!sel_valid && !F_FULL)) begin
          state_nxt = IDLE;
          rr_nxt    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      WR_CNT   <= '0;
      OVF_ERR  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      if (beat && (WR_CNT != '1)) begin
        WR_CNT <= WR_CNT + 1'b1;
      end
      if (F_WR_ERROR) begin
        OVF_ERR <= 1'b1;
      end
    end
  end

  // Data is forced to zero outside a burst so the port is quiet in IDLE.
  always_comb begin
    B_DI = '0;
    if (state == BURST) begin
`ifdef ILA_ARB_TAG_EN
      B_DI = FIFO_W'({grant, sel_data});
`else
      B_DI = FIFO_W'(sel_data);
`endif
    end
  end

  assign B_EN        = beat;
  assign B_WE        = beat;
  assign B_BM        = '1;
  assign GRANT_VALID = (state == BURST);
  assign GRANT_ID    = grant;

endmodule
